// File: rtl/instr_encode_loader.sv
// Packs R/I/J instruction fields into 32-bit MIPS words and streams them into imem.
// Optional macro INSTR_ENC_RANGE_CHECK_EN flags I-type immediates that do not fit in 16 signed bits.
module instr_encode_loader #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [5:0]            opcode,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [31:0]           imm,
    input  logic [25:0]           jtarget,
    input  logic                  last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  overflow,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    we_q, we_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;
    logic [31:0]             packed_word;
    logic                    fmt_bad;
    logic                    accept;

    always_comb begin
        packed_word = 32'h0;
        fmt_bad     = 1'b0;
        case (fmt)
            2'b00:   packed_word = {opcode, rs, rt, rd, shamt, funct};
            2'b01:   packed_word = {opcode, rs, rt, imm[15:0]};
            2'b10:   packed_word = {opcode, jtarget};
            default: fmt_bad     = 1'b1;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        // Immediate must be a sign extension of its low half to survive encoding.
        if (fmt == 2'b01 && imm[31:16] != {16{imm[15]}}) fmt_bad = 1'b1;
`endif
    end

`ifndef INSTR_ENC_RANGE_CHECK_EN
    logic imm_hi_unused;
    assign imm_hi_unused = ^imm[31:16];
`endif

    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        we_d    = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = BASE_ADDR;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = packed_word;
                    count_d = count_q + CNT_ONE;
                    if (fmt_bad) err_d = 1'b1;
                    // The pointer stops at the top word; running into it ends the load.
                    if (ptr_q == TOP_ADDR) begin
                        state_d = S_DONE;
                        if (!last) ovf_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                        if (last) state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE_ADDR;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
            count_q <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = (state_q == S_DONE);
    assign overflow   = ovf_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed steps plus random beats against a field-level model.
module tb_instr_encode_loader;
    logic clk = 1'b0;
    logic reset, start, in_valid, last;
    logic [1:0] fmt;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;
    logic [31:0] imm;
    logic [25:0] jtarget;

    logic in_ready, imem_we, done, overflow, err;
    logic [9:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] count;

    logic s_start, s_valid;
    logic s_ready, s_we, s_done, s_ovf, s_err;
    logic [1:0] s_addr;
    logic [31:0] s_wdata;
    logic [2:0] s_count;

    int passes = 0, fails = 0, total = 0;

    // model state
    bit m_load, m_done, m_err, m_ovf, m_we;
    int m_ptr, m_cnt, m_addr;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .jtarget(jtarget), .last(last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .done(done), .overflow(overflow), .err(err));

    instr_encode_loader #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .jtarget(jtarget), .last(last), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .count(s_count), .done(s_done), .overflow(s_ovf), .err(s_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
        input logic [5:0] fn, input logic [31:0] im, input logic [25:0] jt);
        logic [31:0] w;
        case (f)
            2'd0: w = 32'(op) * 67108864 + 32'(s) * 2097152 + 32'(t) * 65536
                      + 32'(d) * 2048 + 32'(sh) * 64 + 32'(fn);
            2'd1: w = 32'(op) * 67108864 + 32'(s) * 2097152 + 32'(t) * 65536 + (im % 65536);
            2'd2: w = 32'(op) * 67108864 + 32'(jt);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic bit imm_out_of_range(input logic [31:0] im);
        return (im >> 15) != 32'h0 && (im >> 15) != 32'h1FFFF;
    endfunction

    task automatic model_reset();
        m_load = 0; m_done = 0; m_err = 0; m_ovf = 0; m_we = 0;
        m_ptr = 0; m_cnt = 0; m_addr = 0; m_wdata = 32'h0;
    endtask

    // One clock: update model from the inputs present at the edge, then compare everything.
    task automatic tick();
        bit acc;
        acc  = m_load && in_valid;
        m_we = 0;
        if (reset) model_reset();
        else if (!m_load && start) begin
            m_load = 1; m_done = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_ovf = 0;
        end else if (acc) begin
            m_we = 1;
            m_wdata = enc(fmt, opcode, rs, rt, rd, shamt, funct, imm, jtarget);
            m_addr = m_ptr;
            m_cnt++;
            if (fmt == 2'd3) m_err = 1;
`ifdef INSTR_ENC_RANGE_CHECK_EN
            if (fmt == 2'd1 && imm_out_of_range(imm)) m_err = 1;
`endif
            if (m_ptr == 1023) begin
                m_load = 0; m_done = 1;
                if (!last) m_ovf = 1;
            end else begin
                m_ptr++;
                if (last) begin m_load = 0; m_done = 1; end
            end
        end
        @(posedge clk); #1;
        chk("in_ready", in_ready, m_load);
        chk("imem_we", imem_we, m_we);
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("count", count, m_cnt);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("err", err, m_err);
    endtask

    task automatic beat(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
        input logic [31:0] im, input logic [25:0] jt, input logic lst);
        fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
        imm = im; jtarget = jt; last = lst; in_valid = 1'b1;
    endtask

    initial begin
        reset = 1; start = 0; in_valid = 0; last = 0; s_start = 0; s_valid = 0;
        fmt = 0; opcode = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; jtarget = 0;
        model_reset();
        tick();
        chk("rst_count", count, 32'h0);
        reset = 0;

        // R-type add
        start = 1; tick(); start = 0;
        beat(2'd0, 6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 32'h0, 26'h0, 1'b1); tick(); in_valid = 0;
        chk("t1_wdata", imem_wdata, 32'h012A4020);
        chk("t1_addr", imem_addr, 32'h0);

        // I then J
        start = 1; tick(); start = 0;
        beat(2'd1, 6'd8, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'hFFFFFFFF, 26'h0, 1'b0); tick();
        chk("t2_iword", imem_wdata, 32'h2008FFFF);
        beat(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0, 26'h0100000, 1'b1); tick(); in_valid = 0;
        chk("t2_jword", imem_wdata, 32'h08100000);
        chk("t2_addr", imem_addr, 32'h1);
        chk("t2_done", done, 32'h1);
        chk("t2_count", count, 32'h2);
        tick();
        chk("t2_hold_we", imem_we, 32'h0);
        chk("t2_hold_addr", imem_addr, 32'h1);

        // illegal fmt
        start = 1; tick(); start = 0;
        beat(2'd3, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 32'hFFFFFFFF, 26'h3FFFFFF, 1'b0); tick();
        chk("t4_nop", imem_wdata, 32'h0);
        chk("t4_err", err, 32'h1);
        start = 1; // ignored while loading
        beat(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 32'h0, 26'h0, 1'b1); tick(); in_valid = 0;
        chk("t4_start_ignored_cnt", count, 32'h2);
        tick(); start = 0;
        chk("t4_err_clr", err, 32'h0);

        // I immediate outside 16-bit signed range
        beat(2'd1, 6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h00018000, 26'h0, 1'b1); tick(); in_valid = 0;
        chk("t6_lo16", imem_wdata & 32'hFFFF, 32'h8000);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        chk("t6_err", err, 32'h1);
`else
        chk("t6_err", err, 32'h0);
`endif

        // reset coinciding with an accepted beat drops the write
        start = 1; tick(); start = 0;
        beat(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 32'h0, 26'h0, 1'b0);
        reset = 1; tick(); reset = 0; in_valid = 0;
        chk("t5_we", imem_we, 32'h0);
        chk("t5_wdata", imem_wdata, 32'h0);
        tick();

        // small memory overflow
        beat(2'd0, 6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20, 32'h0, 26'h0, 1'b0); in_valid = 0;
        s_start = 1; @(posedge clk); #1; s_start = 0; s_valid = 1;
        chk("t3_ready", s_ready, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t3_we", s_we, 32'h1);
            chk("t3_addr", s_addr, 32'(i));
        end
        chk("t3_done", s_done, 32'h1);
        chk("t3_ovf", s_ovf, 32'h1);
        chk("t3_count", s_count, 32'h4);
        chk("t3_ready_off", s_ready, 32'h0);
        @(posedge clk); #1; s_valid = 0;
        chk("t3_no5th", s_we, 32'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            start = ($urandom % 8) == 0;
            beat(2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 6'($urandom),
                 ($urandom % 2) ? $urandom : 32'($signed(16'($urandom))),
                 26'($urandom), ($urandom % 12) == 0);
            in_valid = ($urandom % 3) != 0;
            tick();
        end
        in_valid = 0; start = 0; tick();

        // fill the whole 1024-word memory without last
        start = 1; tick(); start = 0;
        for (int n = 0; n < 1024; n++) begin
            beat(2'($urandom % 3), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 6'($urandom), 32'($signed(16'($urandom))), 26'($urandom), 1'b0);
            tick();
        end
        chk("top_addr", imem_addr, 32'd1023);
        chk("top_ovf", overflow, 32'h1);
        chk("top_count", count, 32'd1024);
        tick();
        in_valid = 0;
        chk("top_after_we", imem_we, 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
